renkon_pool_stream: RTL and testbench
=====================================

// Module: renkon_pool_stream
// PURPOSE
//  Streaming signed max-pool stage; sits between the per-core conv/bias/activation output and the image-memory writeback.
//  Successor to the fixed 2x2, single-lane pool: runtime pool size 1..PMAX, runtime map side up to MAXW, LANES parallel cores.
//  Pool stride always equals pool size.
//  One conv output map per start; raster-order pixels in, pooled pixels out in raster order.
// PARAMETERS
//  LANES  CORE    parallel channels (one per PE), all sharing one pixel position
//  DW     DWIDTH  signed pixel width
//  MAXW   32      largest accepted fmap side (sets row-buffer depth MAXW)
//  PMAX   4       largest accepted pool size
// PORTS
//  clk        in   1           clock
//  rst        in   1           asynchronous, active-high reset
//  start      in   1           latch fmap_size/pool_size and begin a map; honoured in IDLE only
//  fmap_size  in   LWIDTH      input map side F
//  pool_size  in   LWIDTH      pool window side P
//  in_valid   in   1           pixel beat valid; no backpressure
//  pixel_in   in   LANES*DW    signed pixels, lane l in bits [l*DW +: DW]
//  out_valid  out  1           pooled beat valid
//  pixel_out  out  LANES*DW    signed pooled maxima
//  busy       out  1           high in RUN
//  done       out  1           one-cycle pulse at end of map
//  err        out  1           one-cycle pulse on rejected start
// BEHAVIOUR
//  Reset: state IDLE; all counters zero; out_valid, busy, done and err =0; pixel_out =0. Row-buffer contents are don't-care.
//  FSM IDLE->RUN on a valid start. RUN->DONE on the cycle after the F*F-th accepted beat. DONE->IDLE unconditionally.
//   done =1 only in DONE.
//  start validity: rejected if P==0, P>PMAX, F>MAXW or F<P. On rejection err pulses next cycle and the FSM stays IDLE.
//  start is ignored in RUN and DONE.
//  in_valid is ignored outside RUN; such beats are dropped, not buffered.
//  Counters, none using a divider:
//   ix = column 0..F-1; iy = row 0..F-1.
//   px = column within window 0..P-1; py = row within window 0..P-1.
//   ox = output column. All advance only on accepted beats.
//  Window coverage: Q = floor(F/P). Pixels with ix>=Q*P or iy>=Q*P are consumed and discarded; they do not affect any output.
//  Per lane: hmax = running max over px within a window row; px==0 loads the pixel directly.
//  At px==P-1:
//   m = (py==0) ? hmax' : max(rowbuf[ox], hmax'), where hmax' includes the current pixel.
//   If py<P-1, write m to rowbuf[ox].
//   If py==P-1, present m on pixel_out with out_valid=1 on the next cycle.
//  Latency: out_valid exactly 1 cycle after the beat that completes a window. Maxima use signed comparison.
//  P==1 is pass-through with 1-cycle latency: Q*Q = F*F outputs.
//  Output count per map is exactly Q*Q. pixel_out holds its last value when out_valid=0.
//  When the final beat also completes the last window, out_valid and done are asserted in the same cycle.
//  Gaps in in_valid are arbitrary; behaviour depends only on accepted beats.
//  rst mid-map: immediate abort to IDLE, no done; the next start begins clean.
//  Arithmetic: no widening. max() selects an operand, so no overflow is possible.
// STRUCTURE
//  renkon.svh additions: PMAX and MAXW defaults; typedef enum {POOL_IDLE, POOL_RUN, POOL_DONE} pool_state_t.
//  Sub-module renkon_pool_rowbuf: MAXW x (LANES*DW) partial-max store with 1 write port and 1 async read port at ox.
//   It is instantiated once.
//  Top module holds the FSM, the five counters, the LANES hmax registers and the output register.
// TESTING
//  1. F=4, P=2, LANES=2, lane0 = 0..15 raster, lane1 = -(0..15):
//     -> 4 outputs; lane0 {5,7,13,15}; lane1 {0,-2,-8,-10}; done one cycle after beat 16.
//  2. F=5, P=2, lane0 = 0..24:
//     -> 4 outputs {6,8,16,18}; column 4 and row 4 discarded.
//     -> done after beat 25; no out_valid after the 4th output.
//  3. F=6, P=3, all-negative map with -1 at (4,4), others -100:
//     -> 4 outputs {-100,-100,-100,-1}.
//  4. P=1, F=3, random data with random in_valid gaps -> 9 outputs equal to inputs, each 1 cycle after its beat.
//  5. start with P=0, then P=5, then F=2/P=3 -> err pulse each time, busy stays 0, no outputs.
//     Then a valid F=4/P=2 map passes.
//  6. rst asserted after beat 7 of test 1 -> out_valid/busy/done drop asynchronously.
//     Rerun of test 1 gives identical results; start during RUN is ignored.

Source files
------------

// File: rtl/renkon_pool_stream_pkg.sv
// Shared constants and state encoding for the streaming max-pool stage.
// Contents:
//   CORE, DWIDTH        default lane count and signed pixel width
//   DEF_MAXW, DEF_PMAX  default largest map side and largest pool size
//   pool_state_t        FSM state type; POOL_IDLE / POOL_RUN / POOL_DONE
package renkon_pool_stream_pkg;

    localparam int unsigned CORE     = 2;
    localparam int unsigned DWIDTH   = 16;
    localparam int unsigned DEF_MAXW = 32;
    localparam int unsigned DEF_PMAX = 4;

    typedef logic [1:0] pool_state_t;

    localparam pool_state_t POOL_IDLE = 2'd0;
    localparam pool_state_t POOL_RUN  = 2'd1;
    localparam pool_state_t POOL_DONE = 2'd2;

endpackage

// File: rtl/renkon_pool_rowbuf.sv
// Partial-max row buffer: one slot per output column of the window row in progress.
// Ports:
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write slot (output column)
//   wdata  in  per-lane partial maxima
//   raddr  in  read slot (output column)
//   rdata  out per-lane partial maxima, combinational read
module renkon_pool_rowbuf #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned W     = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Contents need no reset: every slot is written on the first window row before it is read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/renkon_pool_stream.sv
// Streaming signed max-pool stage, pool stride equal to pool size, LANES parallel channels.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   start       latch fmap_size/pool_size and begin a map (IDLE only)
//   fmap_size   input map side F
//   pool_size   pool window side P
//   in_valid    pixel beat valid, no backpressure
//   pixel_in    signed pixels, lane l in [l*DW +: DW]
//   out_valid   pooled beat valid
//   pixel_out   pooled maxima, held while out_valid is low
//   busy        high while a map is in progress
//   done        one-cycle pulse at end of map
//   err         one-cycle pulse on a rejected start
module renkon_pool_stream
    import renkon_pool_stream_pkg::*;
#(
    parameter int unsigned LANES  = CORE,
    parameter int unsigned DW     = DWIDTH,
    parameter int unsigned MAXW   = DEF_MAXW,
    parameter int unsigned PMAX   = DEF_PMAX,
    parameter int unsigned LWIDTH = $clog2(MAXW + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LWIDTH-1:0]     fmap_size,
    input  logic [LWIDTH-1:0]     pool_size,
    input  logic                  in_valid,
    input  logic [LANES*DW-1:0]   pixel_in,
    output logic                  out_valid,
    output logic [LANES*DW-1:0]   pixel_out,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned BW = LANES * DW;
    localparam int unsigned AW = (MAXW > 1) ? $clog2(MAXW) : 1;
    localparam int unsigned CW = LWIDTH + 1;

    pool_state_t        state, state_n;
    logic [LWIDTH-1:0]  fmap_q, fmap_n;
    logic [LWIDTH-1:0]  pool_q, pool_n;
    logic [LWIDTH-1:0]  ix, ix_n, iy, iy_n;
    logic [LWIDTH-1:0]  px, px_n, py, py_n;
    logic [AW-1:0]      ox, ox_n;
    logic [BW-1:0]      hmax, hmax_n;
    logic               out_valid_n, busy_n, done_n, err_n;
    logic [BW-1:0]      pixel_out_n;

    logic               start_bad_c;
    logic               col_ok_c, row_ok_c;
    logic [BW-1:0]      hmax_cur_c, win_m_c;
    logic               rb_we_c;
    logic [BW-1:0]      rb_wdata_c, rb_rdata_c;

    logic signed [DW-1:0] lane_pix, lane_hm, lane_rb, lane_h, lane_m;

    renkon_pool_rowbuf #(
        .DEPTH (MAXW),
        .AW    (AW),
        .W     (BW)
    ) u_rowbuf (
        .clk   (clk),
        .we    (rb_we_c),
        .waddr (ox),
        .wdata (rb_wdata_c),
        .raddr (ox),
        .rdata (rb_rdata_c)
    );

    assign start_bad_c = (pool_size == '0) ||
                         (pool_size > LWIDTH'(PMAX)) ||
                         (fmap_size > LWIDTH'(MAXW)) ||
                         (fmap_size < pool_size);

    // The window containing this pixel starts at ix-px (iy-py); it is covered only if it ends inside the map.
    assign col_ok_c = (CW'(ix) - CW'(px) + CW'(pool_q)) <= CW'(fmap_q);
    assign row_ok_c = (CW'(iy) - CW'(py) + CW'(pool_q)) <= CW'(fmap_q);

    // Per-lane running row max including the current pixel, and the window max merged with the row buffer.
    always_comb begin
        hmax_cur_c = '0;
        win_m_c    = '0;
        lane_pix   = '0;
        lane_hm    = '0;
        lane_rb    = '0;
        lane_h     = '0;
        lane_m     = '0;
        for (int l = 0; l < int'(LANES); l++) begin
            lane_pix = pixel_in[l*DW +: DW];
            lane_hm  = hmax[l*DW +: DW];
            lane_rb  = rb_rdata_c[l*DW +: DW];
            lane_h   = ((px == '0) || (lane_pix > lane_hm)) ? lane_pix : lane_hm;
            lane_m   = ((py == '0) || (lane_h >= lane_rb)) ? lane_h : lane_rb;
            hmax_cur_c[l*DW +: DW] = lane_h;
            win_m_c[l*DW +: DW]    = lane_m;
        end
    end

    // Next-state, counter and output logic.
    always_comb begin
        state_n     = state;
        fmap_n      = fmap_q;
        pool_n      = pool_q;
        ix_n        = ix;
        iy_n        = iy;
        px_n        = px;
        py_n        = py;
        ox_n        = ox;
        hmax_n      = hmax;
        out_valid_n = 1'b0;
        pixel_out_n = pixel_out;
        err_n       = 1'b0;
        rb_we_c     = 1'b0;
        rb_wdata_c  = '0;

        case (state)
            POOL_IDLE: begin
                if (start) begin
                    if (start_bad_c) begin
                        err_n = 1'b1;
                    end else begin
                        state_n = POOL_RUN;
                        fmap_n  = fmap_size;
                        pool_n  = pool_size;
                        ix_n    = '0;
                        iy_n    = '0;
                        px_n    = '0;
                        py_n    = '0;
                        ox_n    = '0;
                    end
                end
            end
            POOL_RUN: begin
                if (in_valid) begin
                    hmax_n = hmax_cur_c;
                    if (px == pool_q - LWIDTH'(1)) begin
                        px_n = '0;
                        if (col_ok_c && row_ok_c) begin
                            if (py == pool_q - LWIDTH'(1)) begin
                                out_valid_n = 1'b1;
                                pixel_out_n = win_m_c;
                            end else begin
                                rb_we_c    = 1'b1;
                                rb_wdata_c = win_m_c;
                            end
                            ox_n = ox + AW'(1);
                        end
                    end else begin
                        px_n = px + LWIDTH'(1);
                    end
                    // End of an input row: a partial trailing window is abandoned.
                    if (ix == fmap_q - LWIDTH'(1)) begin
                        ix_n = '0;
                        px_n = '0;
                        ox_n = '0;
                        py_n = (py == pool_q - LWIDTH'(1)) ? '0 : py + LWIDTH'(1);
                        if (iy == fmap_q - LWIDTH'(1)) begin
                            state_n = POOL_DONE;
                        end else begin
                            iy_n = iy + LWIDTH'(1);
                        end
                    end else begin
                        ix_n = ix + LWIDTH'(1);
                    end
                end
            end
            POOL_DONE: begin
                state_n = POOL_IDLE;
            end
            default: begin
                state_n = POOL_IDLE;
            end
        endcase

        busy_n = (state_n == POOL_RUN);
        done_n = (state_n == POOL_DONE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= POOL_IDLE;
            fmap_q    <= '0;
            pool_q    <= '0;
            ix        <= '0;
            iy        <= '0;
            px        <= '0;
            py        <= '0;
            ox        <= '0;
            hmax      <= '0;
            out_valid <= 1'b0;
            pixel_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            fmap_q    <= fmap_n;
            pool_q    <= pool_n;
            ix        <= ix_n;
            iy        <= iy_n;
            px        <= px_n;
            py        <= py_n;
            ox        <= ox_n;
            hmax      <= hmax_n;
            out_valid <= out_valid_n;
            pixel_out <= pixel_out_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
        end
    end

endmodule

// File: tb/tb_renkon_pool_stream.sv
// Scoreboard bench for renkon_pool_stream: the driver pushes window maxima computed
// from a whole-map array; a negedge monitor pops them as the DUT presents outputs.
module tb_renkon_pool_stream;

    localparam int LANES = 2;
    localparam int DW    = 16;
    localparam int MAXW  = 32;
    localparam int PMAX  = 4;
    localparam int LW    = $clog2(MAXW + 1);
    localparam int BW    = LANES * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] fmap_size = '0;
    logic [LW-1:0] pool_size = '0;
    logic          in_valid = 1'b0;
    logic [BW-1:0] pixel_in = '0;
    logic          out_valid;
    logic [BW-1:0] pixel_out;
    logic          busy;
    logic          done;
    logic          err;

    renkon_pool_stream #(
        .LANES (LANES),
        .DW    (DW),
        .MAXW  (MAXW),
        .PMAX  (PMAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .fmap_size (fmap_size),
        .pool_size (pool_size),
        .in_valid  (in_valid),
        .pixel_in  (pixel_in),
        .out_valid (out_valid),
        .pixel_out (pixel_out),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [BW-1:0] d;
        int            c;
    } exp_t;

    exp_t          expq[$];
    int            checks = 0;
    int            errors = 0;
    int            exp_done_cyc = -1;
    int            exp_err_cyc = -1;
    int            done_cnt = 0;
    int            err_cnt = 0;
    int            out_cnt = 0;
    logic [BW-1:0] last_out = '0;
    logic signed [DW-1:0] mp [LANES][MAXW*MAXW];

    task automatic chk(input string name, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: compare every presented output with the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid) begin
                out_cnt++;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: out_valid=1 data 0x%0h at cycle %0d, want no output", pixel_out, cyc);
                    last_out = pixel_out;
                end else begin
                    e = expq.pop_front();
                    chk("out_data", longint'(pixel_out), longint'(e.d));
                    chk("out_cycle", cyc, e.c);
                    last_out = e.d;
                end
            end else begin
                chk("out_hold", longint'(pixel_out), longint'(last_out));
            end
            if (done) begin
                done_cnt++;
                chk("done_cycle", cyc, exp_done_cyc);
                exp_done_cyc = -1;
            end
            if (err) begin
                err_cnt++;
                chk("err_cycle", cyc, exp_err_cyc);
                exp_err_cyc = -1;
            end
        end
    end

    // mode 0: lane0 = raster index, lane1 = -index; 1: lane0 index, lane1 random;
    // 2: all -100 with -1 at (4,4); 3: random.
    task automatic fill(input int mode, input int f);
        for (int k = 0; k < f * f; k++) begin
            for (int l = 0; l < LANES; l++) begin
                case (mode)
                    0: mp[l][k] = (l == 0) ? DW'(k) : DW'(-k);
                    1: mp[l][k] = (l == 0) ? DW'(k) : DW'($urandom);
                    2: mp[l][k] = (k == 4 * f + 4) ? DW'(-1) : DW'(-100);
                    default: mp[l][k] = DW'($urandom);
                endcase
            end
        end
    endtask

    task automatic run_map(input int f, input int p, input int gap, input bit mid_start, input int abort_at);
        int q;
        int ix;
        int iy;
        int done0;
        int out0;
        logic [BW-1:0] e;
        logic signed [DW-1:0] mx;
        q     = f / p;
        done0 = done_cnt;
        out0  = out_cnt;
        @(negedge clk);
        start = 1'b1;
        fmap_size = LW'(f);
        pool_size = LW'(p);
        @(negedge clk);
        start = 1'b0;
        chk("busy_run", busy, 1);
        for (int k = 0; k < f * f; k++) begin
            while (gap > 0 && $urandom_range(99) < gap) begin
                in_valid = 1'b0;
                pixel_in = BW'($urandom);
                @(negedge clk);
            end
            if (k == abort_at) begin
                in_valid = 1'b0;
                chk("busy_pre_abort", busy, 1);
                #2 rst = 1'b1;
                #1;
                chk("abort_out_valid", out_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                expq.delete();
                exp_done_cyc = -1;
                @(negedge clk);
                rst = 1'b0;
                last_out = '0;
                return;
            end
            iy = k / f;
            ix = k % f;
            in_valid = 1'b1;
            for (int l = 0; l < LANES; l++) pixel_in[l*DW +: DW] = mp[l][k];
            if (mid_start && k == f) begin
                start = 1'b1;
                fmap_size = LW'(3);
                pool_size = LW'(1);
            end else begin
                start = 1'b0;
            end
            if (ix % p == p - 1 && iy % p == p - 1 && ix < q * p && iy < q * p) begin
                for (int l = 0; l < LANES; l++) begin
                    mx = mp[l][(iy - p + 1) * f + (ix - p + 1)];
                    for (int dy = 0; dy < p; dy++)
                        for (int dx = 0; dx < p; dx++)
                            if (mp[l][(iy - p + 1 + dy) * f + (ix - p + 1 + dx)] > mx)
                                mx = mp[l][(iy - p + 1 + dy) * f + (ix - p + 1 + dx)];
                    e[l*DW +: DW] = mx;
                end
                expq.push_back('{e, cyc + 1});
            end
            if (k == f * f - 1) exp_done_cyc = cyc + 1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_count", done_cnt - done0, 1);
        chk("out_count", out_cnt - out0, q * q);
        chk("queue_drained", expq.size(), 0);
        chk("busy_idle", busy, 0);
    endtask

    task automatic bad_start(input int f, input int p);
        int err0;
        err0 = err_cnt;
        @(negedge clk);
        start = 1'b1;
        fmap_size = LW'(f);
        pool_size = LW'(p);
        exp_err_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        chk("bad_busy", busy, 0);
        @(negedge clk);
        chk("err_count", err_cnt - err0, 1);
        chk("bad_busy2", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pixel_out", longint'(pixel_out), 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);

        // Beats while idle must be dropped.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            pixel_in = BW'($urandom);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        fill(0, 4); run_map(4, 2, 0, 1'b0, -1);
        fill(1, 5); run_map(5, 2, 30, 1'b0, -1);
        fill(2, 6); run_map(6, 3, 0, 1'b0, -1);
        fill(3, 3); run_map(3, 1, 40, 1'b0, -1);

        bad_start(4, 0);
        bad_start(4, 5);
        bad_start(2, 3);
        bad_start(33, 2);
        fill(3, 4); run_map(4, 2, 20, 1'b0, -1);

        fill(0, 4); run_map(4, 2, 0, 1'b0, 7);
        fill(0, 4); run_map(4, 2, 0, 1'b1, -1);

        fill(3, 7);  run_map(7, 3, 25, 1'b1, -1);
        fill(3, 9);  run_map(9, 4, 10, 1'b0, -1);
        fill(3, 1);  run_map(1, 1, 0, 1'b0, -1);
        fill(3, 4);  run_map(4, 4, 15, 1'b0, -1);
        fill(3, 32); run_map(32, 4, 10, 1'b0, -1);
        fill(3, 32); run_map(32, 1, 5, 1'b0, -1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
